// File: rtl/pipemem_ctl.sv
// Pipelined-CPU data memory: byte/half/word stores, extended registered loads,
// post-reset clear sequencer and access exceptions. Optional parity: DMEM_PARITY_EN.
module pipemem_ctl #(
    parameter int          AW      = 5,
    parameter logic [31:0] CLR_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        perr_inj,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [1:0]  exc_cause,
    output logic        perr
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          clr_we;
    logic [AW-1:0] cnt;
    logic [31:0]   ram [DEPTH];

    logic          accept;
    logic          exc_hit;
    logic [1:0]    cause_nx;
    logic          addr_hi_nz;
    logic          ld_ok;
    logic          st_ok;
    logic [AW-1:0] idx;
    logic [3:0]    lane_mask;
    logic [31:0]   lane_data;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_value;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: if (cnt == {AW{1'b1}}) state_nx = ST_IDLE;
            ST_IDLE:  state_nx = ST_IDLE;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        clr_we = 1'b0;
        case (state)
            ST_CLEAR: clr_we = 1'b1;
            ST_IDLE:  ready  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (clr_we) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign accept     = ready & req;
    assign addr_hi_nz = |(addr >> (AW + 2));
    assign idx        = addr[AW+1:2];

    // Exception priority: illegal size, then misalignment, then range.
    always_comb begin
        exc_hit  = 1'b0;
        cause_nx = 2'b00;
        if (size == 2'b11) begin
            exc_hit  = 1'b1;
            cause_nx = 2'b11;
        end else if ((size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00)) begin
            exc_hit  = 1'b1;
            cause_nx = 2'b01;
        end else if (addr_hi_nz) begin
            exc_hit  = 1'b1;
            cause_nx = 2'b10;
        end
    end

    assign ld_ok = accept & ~we & ~exc_hit;
    assign st_ok = accept &  we & ~exc_hit;

    always_comb begin
        lane_mask = 4'b0000;
        lane_data = wdata;
        case (size)
            2'b00: begin
                lane_mask = 4'b0001 << addr[1:0];
                lane_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[cnt] <= CLR_VAL;
        end else if (st_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) ram[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    // The array is read combinationally so a store on the previous edge is visible.
    assign rd_word = ram[idx];
    assign rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_value = rd_word;
        case (size)
            2'b00:   ld_value = sext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'b01:   ld_value = sext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: ld_value = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rvalid    <= 1'b0;
            rdata     <= '0;
            exc       <= 1'b0;
            exc_cause <= 2'b00;
        end else begin
            rvalid <= ld_ok;
            exc    <= accept & exc_hit;
            if (ld_ok) rdata <= ld_value;
            if (accept && exc_hit) exc_cause <= cause_nx;
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par_mem [DEPTH];
    logic [3:0] clr_par;
    logic [3:0] wr_par;
    logic [3:0] calc_par;
    logic [3:0] rd_par;

    // Even parity per lane: the stored bit equals the XOR of that byte.
    always_comb begin
        clr_par  = '0;
        wr_par   = '0;
        calc_par = '0;
        for (int i = 0; i < 4; i++) begin
            clr_par[i]  = ^CLR_VAL[8*i +: 8];
            wr_par[i]   = (^lane_data[8*i +: 8]) ^ perr_inj;
            calc_par[i] = ^rd_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[cnt] <= clr_par;
        end else if (st_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) par_mem[idx][i] <= wr_par[i];
            end
        end
    end

    assign rd_par = par_mem[idx];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perr <= 1'b0;
        end else begin
            perr <= ld_ok && (rd_par != calc_par);
        end
    end
`else
    logic unused_perr_inj;
    assign unused_perr_inj = perr_inj;
    assign perr            = 1'b0;
`endif

endmodule

// File: tb/tb_pipemem_ctl.sv
// Directed testbench for pipemem_ctl (AW=5, CLR_VAL=0); parity checks follow DMEM_PARITY_EN.
module tb_pipemem_ctl;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        perr_inj = 1'b0;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exc;
    logic [1:0]  exc_cause;
    logic        perr;

    int n_cmp = 0;
    int n_fail = 0;

    pipemem_ctl #(.AW(5), .CLR_VAL(32'h0)) dut (
        .clk(clk), .clrn(clrn), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .perr_inj(perr_inj), .ready(ready),
        .rvalid(rvalid), .rdata(rdata), .exc(exc), .exc_cause(exc_cause), .perr(perr)
    );

    always #5 clk = ~clk;

    // Presents one request for a single accepting edge; returns at edge+1.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d, input logic inj);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d; perr_inj = inj;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; perr_inj = 1'b0;
    endtask

    task automatic count_to_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        #3 clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %b want 0", ready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rvalid: got %b want 0", rvalid); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_rdata: got %h want 0", rdata); end
        n_cmp++; if (exc !== 1'b0 || exc_cause !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_exc: got %b/%b want 0/00", exc, exc_cause); end
        n_cmp++; if (perr !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_perr: got %b want 0", perr); end
        clrn = 1'b1;
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hFFFF_FFFF;
        count_to_ready(n);
        req = 1'b0; we = 1'b0;
        n_cmp++; if (n !== 32) begin n_fail++; $display("[TB] FAIL clear_len: got %0d want 32", n); end
        issue(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL lw_7c: got %b/%h want 1/00000000", rvalid, rdata); end
        issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL lw_00_after_clear: got %b/%h want 1/00000000", rvalid, rdata); end
    endtask

    task automatic test_store_load;
        issue(1'b1, 2'b10, 1'b0, 32'h50, 32'h0000_00a3, 1'b0);
        n_cmp++; if (rvalid !== 1'b0 || exc !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_no_strobe: got %b/%b want 0/0", rvalid, exc); end
        issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h0000_00a3 || exc !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_50: got %b/%h/%b want 1/000000a3/0", rvalid, rdata, exc); end
        @(posedge clk); #1;
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h0000_00a3) begin n_fail++; $display("[TB] FAIL rdata_hold: got %b/%h want 0/000000a3", rvalid, rdata); end
    endtask

    task automatic test_lanes;
        issue(1'b1, 2'b10, 1'b0, 32'h54, 32'h1122_3344, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h55, 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'b10, 1'b1, 32'h54, 32'h0, 1'b0);
        n_cmp++; if (rdata !== 32'h1122_8044) begin n_fail++; $display("[TB] FAIL sb_merge: got %h want 11228044", rdata); end
        issue(1'b0, 2'b00, 1'b1, 32'h55, 32'h0, 1'b0);
        n_cmp++; if (rdata !== 32'hFFFF_FF80) begin n_fail++; $display("[TB] FAIL lb_55: got %h want ffffff80", rdata); end
        issue(1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 1'b0);
        n_cmp++; if (rdata !== 32'h0000_0080) begin n_fail++; $display("[TB] FAIL lbu_55: got %h want 00000080", rdata); end
        issue(1'b0, 2'b01, 1'b0, 32'h56, 32'h0, 1'b0);
        n_cmp++; if (rdata !== 32'h0000_1122) begin n_fail++; $display("[TB] FAIL lhu_56: got %h want 00001122", rdata); end
        issue(1'b0, 2'b01, 1'b1, 32'h54, 32'h0, 1'b0);
        n_cmp++; if (rdata !== 32'hFFFF_8044) begin n_fail++; $display("[TB] FAIL lh_54: got %h want ffff8044", rdata); end
        issue(1'b0, 2'b00, 1'b1, 32'h57, 32'h0, 1'b0);
        n_cmp++; if (rdata !== 32'h0000_0011) begin n_fail++; $display("[TB] FAIL lb_57: got %h want 00000011", rdata); end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 2'b01, 1'b0, 32'h5E, 32'hAAAA_BEEF, 1'b0);
        issue(1'b0, 2'b10, 1'b1, 32'h5C, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'hBEEF_0000) begin n_fail++; $display("[TB] FAIL sh_then_lw: got %b/%h want 1/beef0000", rvalid, rdata); end
        issue(1'b0, 2'b00, 1'b0, 32'h50, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h0000_00a3) begin n_fail++; $display("[TB] FAIL lbu_b2b: got %b/%h want 1/000000a3", rvalid, rdata); end
        issue(1'b1, 2'b00, 1'b0, 32'h5C, 32'h0000_0077, 1'b0);
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_after_load_rvalid: got %b want 0", rvalid); end
        issue(1'b0, 2'b10, 1'b0, 32'h5C, 32'h0, 1'b0);
        n_cmp++; if (rdata !== 32'hBEEF_0077) begin n_fail++; $display("[TB] FAIL sb_then_lw: got %h want beef0077", rdata); end
    endtask

    task automatic test_exceptions;
        issue(1'b0, 2'b10, 1'b0, 32'h52, 32'h0, 1'b0);
        n_cmp++; if (exc !== 1'b1 || exc_cause !== 2'b01 || rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_misalign: got %b/%b/%b want 1/01/0", exc, exc_cause, rvalid); end
        @(posedge clk); #1;
        n_cmp++; if (exc !== 1'b0 || exc_cause !== 2'b01) begin n_fail++; $display("[TB] FAIL cause_hold: got %b/%b want 0/01", exc, exc_cause); end
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF, 1'b0);
        n_cmp++; if (exc !== 1'b1 || exc_cause !== 2'b10) begin n_fail++; $display("[TB] FAIL sw_range: got %b/%b want 1/10", exc, exc_cause); end
        issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h0 || exc !== 1'b0) begin n_fail++; $display("[TB] FAIL range_no_write: got %b/%h/%b want 1/00000000/0", rvalid, rdata, exc); end
        issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0);
        n_cmp++; if (exc !== 1'b1 || exc_cause !== 2'b11 || rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL size_illegal: got %b/%b/%b want 1/11/0", exc, exc_cause, rvalid); end
        issue(1'b1, 2'b11, 1'b0, 32'h8000_0003, 32'h0, 1'b0);
        n_cmp++; if (exc_cause !== 2'b11) begin n_fail++; $display("[TB] FAIL prio_illegal: got %b want 11", exc_cause); end
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0081, 32'h0, 1'b0);
        n_cmp++; if (exc_cause !== 2'b01) begin n_fail++; $display("[TB] FAIL prio_misalign: got %b want 01", exc_cause); end
        issue(1'b1, 2'b10, 1'b0, 32'h5A, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h58, 32'h0, 1'b0);
        n_cmp++; if (rdata !== 32'h0 || exc !== 1'b0) begin n_fail++; $display("[TB] FAIL misalign_no_write: got %h/%b want 00000000/0", rdata, exc); end
    endtask

    task automatic test_parity;
        logic exp_inj;
`ifdef DMEM_PARITY_EN
        exp_inj = 1'b1;
`else
        exp_inj = 1'b0;
`endif
        issue(1'b1, 2'b10, 1'b0, 32'h60, 32'h0000_00ff, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || perr !== exp_inj) begin n_fail++; $display("[TB] FAIL perr_inj: got %b/%b want 1/%b", rvalid, perr, exp_inj); end
        @(posedge clk); #1;
        n_cmp++; if (perr !== 1'b0) begin n_fail++; $display("[TB] FAIL perr_idle: got %b want 0", perr); end
        issue(1'b1, 2'b10, 1'b0, 32'h60, 32'h0000_00ff, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || perr !== 1'b0 || rdata !== 32'h0000_00ff) begin n_fail++; $display("[TB] FAIL perr_clean: got %b/%b/%h want 1/0/000000ff", rvalid, perr, rdata); end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 1'b0);
        clrn = 1'b0;
        @(posedge clk); #1;
        clrn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_clear_ready: got %b want 0", ready); end
        clrn = 1'b0;
        #2;
        n_cmp++; if (ready !== 1'b0 || rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reclear_outputs: got %b/%b want 0/0", ready, rvalid); end
        @(posedge clk); #1;
        clrn = 1'b1;
        count_to_ready(n);
        n_cmp++; if (n !== 32) begin n_fail++; $display("[TB] FAIL reclear_len: got %0d want 32", n); end
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL cleared_word: got %b/%h want 1/00000000", rvalid, rdata); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_lanes();
        test_back_to_back();
        test_exceptions();
        test_parity();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipemem_ctl.md
Name: pipemem_ctl

Overview:
Parametrised data memory for the pipelined CPU MEM stage, successor to the fixed 32-word single-cycle data RAM.
- Adds byte/halfword/word stores with byte lanes, sign/zero-extended loads and a 1-cycle registered read with valid strobe.
- Adds a post-reset clear sequencer, and alignment/range exceptions reported to the CPU's interrupt/exception logic.

Parameters:
AW, 5, word-index width; depth = 2**AW words of 32 bits
CLR_VAL, 32'h0, value written to every word by the clear sequencer

Ports:
clk  in  1  clock; all state on rising edge
clrn  in  1  asynchronous active-low reset
req  in  1  access request, sampled when ready=1
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 illegal
sext  in  1  loads: 1 sign-extend, 0 zero-extend
addr  in  32  byte address
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
perr_inj  in  1  test hook: invert stored parity on this store (used only with DMEM_PARITY_EN)
ready  out  1  1 = accepting requests
rvalid  out  1  one-cycle strobe: rdata holds load result
rdata  out  32  extended load result
exc  out  1  one-cycle exception strobe
exc_cause  out  2  01 misaligned, 10 out of range, 11 illegal size
perr  out  1  parity error, qualified by rvalid

Behaviour:
- Reset (clrn=0, async): state=CLEAR, clear counter=0, ready=0, rvalid=0, rdata=0, exc=0, exc_cause=0, perr=0.
- CLEAR state:
  - Each cycle writes CLR_VAL to ram[cnt], then cnt++.
  - After writing index 2**AW-1, moves to IDLE; ready=1 from the next cycle.
  - Clear takes exactly 2**AW cycles. req is ignored during CLEAR.
- IDLE state: ready=1 constantly (no backpressure); an access is accepted when req=1.
- Exception check on accept, priority high to low:
  - size=11 gives cause 11.
  - half with addr[0]=1, or word with addr[1:0]!=0, gives cause 01.
  - addr[31:AW+2]!=0 gives cause 10.
  - An exception suppresses the write and the rvalid strobe. exc=1 for one cycle, the cycle after accept; exc_cause is held until the next exception.
- Store:
  - RAM is updated at the accepting clock edge.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0}+1..+0.
  - Word: all lanes are written. Unwritten lanes are unchanged.
  - Stores never raise rvalid.
- Load:
  - The RAM word is read at accept. The lane is selected by addr[1:0] (byte) or addr[1] (half), then zero/sign-extended per sext. Word loads ignore sext.
  - The result is registered: rvalid=1 and rdata valid in the cycle after accept.
  - rdata holds its value while rvalid=0.
- Back-to-back requests:
  - A store in cycle n followed by a load of the same word in cycle n+1 returns the new data.
  - One access per cycle.
- Reset mid-clear or mid-access: aborts immediately and the clear restarts from index 0. A store in flight on the edge coinciding with reset assertion is not guaranteed.

Optional Feature:
DMEM_PARITY_EN
- Defined:
  - Each word stores 4 even-parity bits, one per byte lane, updated on the lanes written.
  - When perr_inj=1 on a store, the written lanes' parity bits are inverted.
  - The clear sequencer writes correct parity.
  - On a load, all 4 lanes are checked. perr=1 together with rvalid if any lane mismatches; otherwise perr=0.
  - Exceptions do not check parity.
- Not defined: no parity storage, perr_inj is ignored, perr is constant 0.

Test Plan:
- Reset release (AW=5) -> ready=0 for 32 cycles, ready=1 on cycle 33. Load of 0x7C -> rvalid next cycle, rdata=0.
- sw 0x000000a3 to 0x50, then lw 0x50 in the next cycle -> rvalid=1 one cycle later, rdata=0x000000a3, exc=0.
- sw 0x11223344 to 0x54, then sb 0x80 to 0x55 -> lw 0x54 returns 0x11228044. lb 0x55 sext=1 returns 0xFFFFFF80. lbu 0x55 returns 0x00000080. lhu 0x56 returns 0x00001122.
- lw 0x52 -> exc=1, cause 01, no rvalid. sw to 0x80 -> exc=1, cause 10, and lw 0x00 still returns 0. size=11 -> cause 11.
- clrn pulsed low at clear cycle 10 -> ready stays 0 for a further full 32 cycles. An earlier stored word reads back CLR_VAL.
- With DMEM_PARITY_EN, sw 0x000000ff to 0x60 with perr_inj=1, then lw 0x60 -> rvalid=1, perr=1. The same store with perr_inj=0 gives perr=0. Without the macro, perr=0 in both cases.
